bus_xfer_sequencer: RTL
=======================

// Module: bus_xfer_sequencer
// PURPOSE
//  Drives the datapath bus from the control side. Accepts one transfer command at a time
//  (start + op/src/dst codes) and steps it through one Moore timing step per clock cycle.
//  In each step it asserts the one-hot source *_out select (which feeds the bus mux) and the
//  destination *_in load enables (which capture the bus), until the command completes.
//  Sits between the control unit and the bus mux / register file / Y / Z / HI / LO.
// PARAMETERS
//  NREG   16  number of general registers R0..R(NREG-1); fixed at 16 by the 5-bit code map
//  CODEW  5   width of a bus source/destination code
// PORTS
//  clock      in   1   system clock, rising edge
//  clear_n    in   1   asynchronous active-low reset
//  start      in   1   command request; sampled only when busy=0
//  op         in   2   0 MOVE, 1 ALU, 2 MULDIV, 3 IMM
//  src_a      in   5   first source code
//  src_b      in   5   second source code (ALU, MULDIV)
//  dst        in   5   destination code (MOVE, ALU, IMM)
//  alu_op     in   4   ALU function; passed through to alu_op_q
//  out_sel    out  24  one-hot bus source select: bits 0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh,
//                      19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C (sign-extended immediate)
//  in_sel     out  22  load enables: bits 0-15 R0-R15, 16 HI, 17 LO, 20 PC, 21 MDR (18,19 tied 0)
//  y_in       out  1   Y register load enable
//  z_in       out  1   Z (64-bit) load enable
//  alu_op_q   out  4   latched ALU function, valid while busy
//  busy       out  1   a command is in progress
//  done       out  1   one-cycle pulse during the final step
//  err        out  1   sticky: illegal dst code seen; cleared by the next accepted start
// BEHAVIOUR
//  - Reset (clear_n=0, asynchronous): state IDLE; every output is 0, including alu_op_q.
//  - All outputs are registered (Moore, decoded from the state and the latched fields).
//    No combinational path runs from the inputs to the outputs.
//  - Accept: when state=IDLE and start=1, latch op/src_a/src_b/dst/alu_op. The first step's
//    outputs appear on the next cycle, and busy rises with them. start is ignored while busy=1.
//  - Invariant: out_sel has at most one bit set (zero bits when IDLE). The bus mux is a
//    priority mux, so two set bits would silently mask one of the sources.
//  - Steps (each is one cycle; done is asserted in the final step):
//      MOVE   T1: out[src_a], in[dst]
//      ALU    T1: out[src_a], y_in   T2: out[src_b], z_in   T3: out[19], in[dst]
//      MULDIV T1: out[src_a], y_in   T2: out[src_b], z_in   T3: out[19], in[17]
//             T4: out[18], in[16]
//      IMM    T1: out[src_a], y_in   T2: out[23], z_in      T3: out[19], in[dst]
//  - Latency, accept to done: MOVE 1, ALU 3, MULDIV 4, IMM 3 cycles after the accepting edge.
//  - Back-to-back: the cycle after the final step, state is IDLE and busy=0. A new start can
//    be accepted on that cycle, so there is a one-cycle gap between commands.
//  - Source code >=24: out_sel stays 0 for that step; the bus mux defaults to C.
//  - Illegal dst (18, 19, 22, 23, >=24): in_sel stays 0 for that step, err is set, and the
//    sequence still completes with normal timing.
//  - MOVE with src_a == dst is legal: out and in are asserted in the same cycle.
//  - clear_n asserted mid-command: immediate return to IDLE, all outputs 0, and the command
//    is lost with no done pulse.
// STRUCTURE
//  - Shared package bus_pkg: op encodings (OP_MOVE..OP_IMM), bus code constants
//    (BUS_HI=16, BUS_LO=17, BUS_ZHI=18, BUS_ZLO=19, BUS_PC=20, BUS_MDR=21, BUS_INP=22,
//    BUS_C=23), and the state enum (IDLE, T1..T4).
//  - Sub-module bus_code_decoder: combinational decode of a 5-bit code to a 24-bit one-hot
//    vector, 0 for codes >=24. Instantiated once for the source and once for the destination;
//    the destination vector is masked to form in_sel. Outputs are registered in the top level.
// TESTING
//  1 Reset: hold clear_n=0 while start=1 -> all outputs 0; after release, one command runs.
//  2 MOVE src=3, dst=7 -> next cycle out_sel=0x000008, in_sel bit 7 set, done=1, busy=1;
//    the following cycle all outputs are 0.
//  3 ALU src_a=1, src_b=2, dst=5, alu_op=4 -> T1 out_sel=0x2 with y_in; T2 out_sel=0x4 with z_in;
//    T3 out_sel=0x080000 with in_sel bit 5 and done; alu_op_q=4 throughout.
//  4 MULDIV a=6, b=9 -> four steps, with LO loaded (bit 17) in T3 and HI loaded (bit 16) in T4;
//    done is asserted only in T4.
//  5 IMM dst=19 -> err=1, in_sel=0 in T3, done still in T3; the next start clears err.
//  6 start pulsed during ALU T2 -> ignored; clear_n dropped in T2 -> outputs 0 at once, no done.
//    On every cycle, an assertion checks that out_sel has at most one bit set.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared encodings for the bus transfer sequencer
//   op_t     command opcodes (MOVE, ALU, MULDIV, IMM)
//   state_t  sequencer timing steps (IDLE, T1..T4)
//   BUS_*    5-bit bus source/destination codes; BUS_NONE selects nothing
package bus_pkg;
    typedef enum logic [1:0] {OP_MOVE, OP_ALU, OP_MULDIV, OP_IMM} op_t;
    typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;
    localparam logic [4:0] BUS_HI   = 5'd16;
    localparam logic [4:0] BUS_LO   = 5'd17;
    localparam logic [4:0] BUS_ZHI  = 5'd18;
    localparam logic [4:0] BUS_ZLO  = 5'd19;
    localparam logic [4:0] BUS_PC   = 5'd20;
    localparam logic [4:0] BUS_MDR  = 5'd21;
    localparam logic [4:0] BUS_INP  = 5'd22;
    localparam logic [4:0] BUS_C    = 5'd23;
    localparam logic [4:0] BUS_NONE = 5'd31;
endpackage

// File: rtl/bus_code_decoder.sv
// bus_code_decoder: 5-bit bus code to 24-bit one-hot vector
//   code  in   bus code
//   vec   out  one-hot select, all zero for codes >= 24
module bus_code_decoder (
    input  logic [4:0]  code,
    output logic [23:0] vec
);
    assign vec = (code < 5'd24) ? (24'd1 << code) : 24'd0;
endmodule

// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: steps one bus transfer command through its Moore timing steps
//   clock, clear_n        clock and asynchronous active-low reset
//   start, op, src_a,     command request and fields, sampled only when idle
//   src_b, dst, alu_op
//   out_sel               registered one-hot bus source select
//   in_sel                registered destination load enables
//   y_in, z_in            Y / Z load enables
//   alu_op_q              latched ALU function while busy
//   busy, done, err       status: in progress, final-step pulse, sticky illegal dst
module bus_xfer_sequencer
    import bus_pkg::*;
#(
    parameter int NREG  = 16,
    parameter int CODEW = 5
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [CODEW-1:0]  src_a,
    input  logic [CODEW-1:0]  src_b,
    input  logic [CODEW-1:0]  dst,
    input  logic [3:0]        alu_op,
    output logic [NREG+7:0]   out_sel,
    output logic [NREG+5:0]   in_sel,
    output logic              y_in,
    output logic              z_in,
    output logic [3:0]        alu_op_q,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t           state, ns;
    op_t              op_q, f_op;
    logic [CODEW-1:0] a_q, b_q, dst_q, f_a, f_b, f_dst, src_code, dst_code;
    logic [3:0]       alu_q, f_alu;
    logic [23:0]      src_vec, dst_vec;
    logic             accept, use_dst, illegal, done_next;

    // Outputs are computed for the step being entered (ns) so they can be
    // registered; on the accepting edge the raw inputs stand in for the latches.
    always_comb begin
        accept    = state == IDLE && start;
        f_op      = accept ? op_t'(op) : op_q;
        f_a       = accept ? src_a : a_q;
        f_b       = accept ? src_b : b_q;
        f_dst     = accept ? dst : dst_q;
        f_alu     = accept ? alu_op : alu_q;
        ns        = state == IDLE ? (start ? T1 : IDLE) :
                    state == T1   ? (op_q == OP_MOVE ? IDLE : T2) :
                    state == T2   ? T3 :
                    state == T3   ? (op_q == OP_MULDIV ? T4 : IDLE) : IDLE;
        src_code  = ns == T1 ? f_a :
                    ns == T2 ? (f_op == OP_IMM ? BUS_C : f_b) :
                    ns == T3 ? BUS_ZLO :
                    ns == T4 ? BUS_ZHI : BUS_NONE;
        use_dst   = (ns == T1 && f_op == OP_MOVE) || (ns == T3 && f_op != OP_MULDIV);
        dst_code  = use_dst  ? f_dst :
                    ns == T3 ? BUS_LO :
                    ns == T4 ? BUS_HI : BUS_NONE;
        // Legal destinations map to exactly one of the loadable bits; anything
        // landing on Z/InPort/C or decoding to nothing is an illegal dst.
        illegal   = use_dst && (dst_vec[23] | dst_vec[22] | dst_vec[19] | dst_vec[18] | ~|dst_vec);
        done_next = (ns == T1 && f_op == OP_MOVE) || (ns == T3 && f_op != OP_MULDIV) || ns == T4;
    end

    bus_code_decoder u_src (.code(src_code), .vec(src_vec));
    bus_code_decoder u_dst (.code(dst_code), .vec(dst_vec));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            op_q     <= OP_MOVE;
            a_q      <= '0;
            b_q      <= '0;
            dst_q    <= '0;
            alu_q    <= '0;
            out_sel  <= '0;
            in_sel   <= '0;
            y_in     <= 1'b0;
            z_in     <= 1'b0;
            alu_op_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= ns;
            if (accept) begin
                op_q  <= f_op;
                a_q   <= src_a;
                b_q   <= src_b;
                dst_q <= dst;
                alu_q <= alu_op;
            end
            out_sel  <= src_vec;
            in_sel   <= {dst_vec[21:20], 2'b00, dst_vec[17:0]};
            y_in     <= ns == T1 && f_op != OP_MOVE;
            z_in     <= ns == T2;
            alu_op_q <= ns == IDLE ? 4'd0 : f_alu;
            busy     <= ns != IDLE;
            done     <= done_next;
            err      <= (err & ~accept) | illegal;
        end
    end
endmodule
